divider: RTL and testbench

Iterative unsigned integer divider: accepts an N-bit dividend and divisor over a valid/ready handshake and returns an N-bit quotient and remainder. It is the inverse companion of the team's pipelined shift-and-add multiplier. Where the multiplier sums shifted partial products, this block performs restoring division, producing one quotient bit per cycle, MSB first. It sits beside the multiplier in the arithmetic datapath and is used standalone or for round-trip checks against it.

---
 rtl/divider_if.sv | 26 ++
 rtl/divider.sv | 92 +++++++++
 tb/tb_divider.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Handshake bundle for the iterative divider: request (a, b) in, result (quot, rem) out.
interface divider_if #(
   parameter int unsigned N = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quot;
   logic [N-1:0] rem;
   logic         div_zero;

   // Requester/consumer side
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, quot, rem, div_zero
   );

   // Divider side
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, quot, rem, div_zero
   );
endinterface

// File: rtl/divider.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, MSB first.
// A zero divisor bypasses the iterations and reports quot = all ones, rem = a.
module divider #(
   parameter int unsigned N = 4
) (
   input logic      clk,
   input logic      rst,
   divider_if.slave bus
);

   localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

   state_t          state;
   // The partial remainder is below b after every step, so its top bit is always 0
   // and only N bits need storing; the (N+1)-bit view lives in trial.
   logic [N-1:0]    p;
   logic [N-1:0]    q;
   logic [N-1:0]    b_reg;
   logic [CntW-1:0] cnt;
   logic [N-1:0]    quot_r;
   logic [N-1:0]    rem_r;
   logic            dz_r;

   logic [N:0]      trial;
   logic [N-1:0]    diff;
   logic            ge;

   // One restoring step: shift in the next dividend bit and trial-subtract b
   assign trial = {p, q[N-1]};
   assign ge    = (trial >= {1'b0, b_reg});
   // When ge holds the difference is below b, so N bits hold it exactly
   assign diff  = trial[N-1:0] - b_reg;

   // Control FSM with datapath and registered results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= StIdle;
         p      <= '0;
         q      <= '0;
         b_reg  <= '0;
         cnt    <= '0;
         quot_r <= '0;
         rem_r  <= '0;
         dz_r   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (bus.in_valid) begin
                  b_reg <= bus.b;
                  if (bus.b == '0) begin
                     quot_r <= '1;
                     rem_r  <= bus.a;
                     dz_r   <= 1'b1;
                     state  <= StDone;
                  end else begin
                     p     <= '0;
                     q     <= bus.a;
                     cnt   <= '0;
                     state <= StCalc;
                  end
               end
            end
            StCalc: begin
               p   <= ge ? diff : trial[N-1:0];
               q   <= {q[N-2:0], ge};
               cnt <= cnt + 1'b1;
               if (cnt == CntW'(N - 1)) begin
                  quot_r <= {q[N-2:0], ge};
                  rem_r  <= ge ? diff : trial[N-1:0];
                  dz_r   <= 1'b0;
                  state  <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state == StIdle);
   assign bus.out_valid = (state == StDone);
   assign bus.quot      = quot_r;
   assign bus.rem       = rem_r;
   assign bus.div_zero  = dz_r;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, backpressure, mid-op reset, full sweep.
module tb_divider;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   divider_if #(.N(N)) bus ();

   divider #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 idle, 1 computing, 2 result presented
   int           m_phase = 0;
   int           m_left  = 0;
   int           m_a     = 0;
   int           m_b     = 0;
   logic [N-1:0] m_quot  = '0;
   logic [N-1:0] m_rem   = '0;
   logic         m_dz    = 1'b0;

   // Model advances on the same edges as the DUT, using plain arithmetic for results
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_left  = 0;
         m_quot  = '0;
         m_rem   = '0;
         m_dz    = 1'b0;
      end else begin
         case (m_phase)
            0: if (bus.in_valid) begin
               m_a = int'(bus.a);
               m_b = int'(bus.b);
               if (m_b == 0) begin
                  m_quot  = N'((1 << N) - 1);
                  m_rem   = N'(m_a);
                  m_dz    = 1'b1;
                  m_phase = 2;
               end else begin
                  m_left  = N;
                  m_phase = 1;
               end
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  m_quot  = N'(m_a / m_b);
                  m_rem   = N'(m_a % m_b);
                  m_dz    = 1'b0;
                  m_phase = 2;
               end
            end
            default: if (bus.out_ready) m_phase = 0;
         endcase
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
         check("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
         check("quot", 32'(bus.quot), 32'(m_quot));
         check("rem", 32'(bus.rem), 32'(m_rem));
         check("div_zero", 32'(bus.div_zero), 32'(m_dz));
         if (bus.out_valid && m_phase == 2 && m_b != 0) begin
            check("identity", 32'(int'(bus.quot) * m_b + int'(bus.rem)), 32'(m_a));
            check("rem_lt_b", 32'(int'(bus.rem) < m_b), 32'd1);
         end
      end
   end

   // Run one request; starts and ends just after a falling edge.
   // lat counts rising edges after the accept edge until out_valid is seen.
   task automatic run_txn(input logic [N-1:0] ta, input logic [N-1:0] tb_, input int stall,
                          input bit poke, output logic [N-1:0] oq, output logic [N-1:0] orr,
                          output logic odz, output int lat);
      int guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("idle_before_request", 32'(bus.in_ready), 32'd1);
      bus.a         = ta;
      bus.b         = tb_;
      bus.in_valid  = 1'b1;
      bus.out_ready = (stall == 0);
      @(posedge clk);
      @(negedge clk);
      // Inputs changed after accept must not matter
      bus.in_valid = 1'b0;
      bus.a        = ~ta;
      bus.b        = ~tb_;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), (tb_ == '0) ? 32'd0 : 32'(N));
      oq  = bus.quot;
      orr = bus.rem;
      odz = bus.div_zero;
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = poke && (i == 1);
         bus.a        = 4'd1;
         bus.b        = 4'd1;
         @(negedge clk);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_quot", 32'(bus.quot), 32'(oq));
         check("hold_rem", 32'(bus.rem), 32'(orr));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] q, r;
      logic         dz;
      int           lat;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;

      // Asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_quot", 32'(bus.quot), 32'd0);
      check("rst_rem", 32'(bus.rem), 32'd0);
      check("rst_div_zero", 32'(bus.div_zero), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases with hand-computed results
      run_txn(4'd13, 4'd3, 0, 1'b0, q, r, dz, lat);
      check("d13_3_quot", 32'(q), 32'd4);
      check("d13_3_rem", 32'(r), 32'd1);
      check("d13_3_dz", 32'(dz), 32'd0);
      check("d13_3_lat", 32'(lat), 32'd4);
      check("d13_3_ready_again", 32'(bus.in_ready), 32'd1);

      run_txn(4'd5, 4'd7, 0, 1'b0, q, r, dz, lat);
      check("d5_7_quot", 32'(q), 32'd0);
      check("d5_7_rem", 32'(r), 32'd5);

      run_txn(4'd15, 4'd1, 0, 1'b0, q, r, dz, lat);
      check("d15_1_quot", 32'(q), 32'd15);
      check("d15_1_rem", 32'(r), 32'd0);

      run_txn(4'd15, 4'd15, 0, 1'b0, q, r, dz, lat);
      check("d15_15_quot", 32'(q), 32'd1);
      check("d15_15_rem", 32'(r), 32'd0);

      // Divide by zero: result visible right after the accept edge
      run_txn(4'd9, 4'd0, 0, 1'b0, q, r, dz, lat);
      check("d9_0_quot", 32'(q), 32'd15);
      check("d9_0_rem", 32'(r), 32'd9);
      check("d9_0_dz", 32'(dz), 32'd1);
      check("d9_0_lat", 32'(lat), 32'd0);

      // Backpressure with an ignored request pulsed during the hold
      run_txn(4'd14, 4'd4, 5, 1'b1, q, r, dz, lat);
      check("d14_4_quot", 32'(q), 32'd3);
      check("d14_4_rem", 32'(r), 32'd2);
      check("d14_4_quot_after", 32'(bus.quot), 32'd3);
      check("d14_4_idle_after", 32'(bus.in_ready), 32'd1);

      // Reset two edges into the calculation
      bus.a        = 4'd14;
      bus.b        = 4'd5;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_quot", 32'(bus.quot), 32'd0);
      check("midrst_rem", 32'(bus.rem), 32'd0);
      check("midrst_dz", 32'(bus.div_zero), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      run_txn(4'd10, 4'd3, 0, 1'b0, q, r, dz, lat);
      check("d10_3_quot", 32'(q), 32'd3);
      check("d10_3_rem", 32'(r), 32'd1);

      // Exhaustive sweep with random consumer stalls
      for (int ia = 0; ia < (1 << N); ia++) begin
         for (int ib = 0; ib < (1 << N); ib++) begin
            run_txn(N'(ia), N'(ib), int'($urandom_range(0, 3)), 1'b0, q, r, dz, lat);
            if (ib == 0) begin
               check("sweep_dz_quot", 32'(q), 32'((1 << N) - 1));
               check("sweep_dz_rem", 32'(r), 32'(ia));
               check("sweep_dz_flag", 32'(dz), 32'd1);
            end else begin
               check("sweep_quot", 32'(q), 32'(ia / ib));
               check("sweep_rem", 32'(r), 32'(ia % ib));
               check("sweep_flag", 32'(dz), 32'd0);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
